// File: rtl/model_port_pkg.sv
// model_port_pkg: state type and small index helpers shared by the model-port arbiter files
package model_port_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    function automatic int data_w(input int msb, input int lsb);
        return msb - lsb + 1;
    endfunction

    function automatic int unsigned onehot_bit(input int unsigned idx);
        return 32'd1 << idx;
    endfunction

    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 == n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/model_port_arbiter_if.sv
// model_port_arbiter_if: requester, shared-instance and response signals around the arbiter
interface model_port_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_MSB = 2,
    parameter int DATA_LSB = -2
);
    import model_port_pkg::*;

    localparam int W  = data_w(DATA_MSB, DATA_LSB);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ*W-1:0]     req_i0;
    logic [NUM_REQ*W-1:0]     req_i1;
    logic [NUM_REQ-1:0]       gnt;
    logic [DATA_MSB:DATA_LSB] shared_i0;
    logic [DATA_LSB:DATA_MSB] shared_i1;
    logic [DATA_MSB:DATA_LSB] shared_o0;
    logic [DATA_LSB:DATA_MSB] shared_o1;
    logic                     rsp_valid;
    logic [IW-1:0]            rsp_id;
    logic [DATA_MSB:DATA_LSB] rsp_o0;
    logic [DATA_LSB:DATA_MSB] rsp_o1;

    modport slave (
        input  req, req_last, req_i0, req_i1, shared_o0, shared_o1,
        output gnt, shared_i0, shared_i1, rsp_valid, rsp_id, rsp_o0, rsp_o1
    );

    modport master (
        output req, req_last, req_i0, req_i1, shared_o0, shared_o1,
        input  gnt, shared_i0, shared_i1, rsp_valid, rsp_id, rsp_o0, rsp_o1
    );

endinterface

// File: rtl/model_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search for the first set request at or after a pointer
module rr_pick #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
        logic [IW:0] s;
        s = {1'b0, a} + (IW+1)'(b);
        return (s >= (IW+1)'(N)) ? IW'(s - (IW+1)'(N)) : s[IW-1:0];
    endfunction

    // scan from the farthest offset down so the nearest requester after ptr wins
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[wrap_add(ptr, i)]) begin
                valid = 1'b1;
                idx   = wrap_add(ptr, i);
            end
        end
    end

endmodule

// File: rtl/model_port_arbiter.sv
// model_port_arbiter: round-robin burst arbiter in front of one shared two-port model instance
module model_port_arbiter
    import model_port_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_MSB  = 2,
    parameter int DATA_LSB  = -2,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    model_port_arbiter_if.slave bus
);

    localparam int W  = data_w(DATA_MSB, DATA_LSB);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    state_t        state, state_nxt;
    logic [IW-1:0] owner, rr_ptr, pick_idx, sel, beat_id;
    logic [CW-1:0] count;
    logic          pick_valid, active, beat, burst_end, beat_q;
    logic [W-1:0]  op0, op1;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (bus.req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign op0 = bus.req_i0[sel*W +: W];
    assign op1 = bus.req_i1[sel*W +: W];

    // grant, beat qualification and next state; IDLE grants the picked requester in the same cycle
    always_comb begin
        sel       = (state == IDLE) ? pick_idx : owner;
        active    = (state == BUSY) || (state == IDLE && pick_valid);
        beat      = active && bus.req[sel];
        burst_end = (state == BUSY && !bus.req[sel]) ||
                    (beat && (bus.req_last[sel] || count == CW'(MAX_BURST - 1)));
        bus.gnt   = active ? NUM_REQ'(onehot_bit(32'(sel))) : '0;
        state_nxt = (state == GAP) ? IDLE : burst_end ? GAP : active ? BUSY : IDLE;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // owner latch, round-robin pointer advance in GAP, beats taken in the current burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner  <= '0;
            rr_ptr <= '0;
            count  <= '0;
        end else begin
            if (state == IDLE) owner <= pick_idx;
            if (state == GAP) rr_ptr <= IW'(next_idx(32'(owner), 32'(NUM_REQ)));
            count <= (state == GAP) ? '0 : beat ? count + 1'b1 : count;
        end
    end

    // operand registers; flat bit j lands on numeric index DATA_LSB+j in either range direction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.shared_i0 <= '0;
            bus.shared_i1 <= '0;
        end else if (beat) begin
            for (int j = 0; j < W; j++) begin
                bus.shared_i0[DATA_LSB + j] <= op0[j];
                bus.shared_i1[DATA_LSB + j] <= op1[j];
            end
        end
    end

    // beat marker delayed to line up with the shared instance output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q  <= 1'b0;
            beat_id <= '0;
        end else begin
            beat_q  <= beat;
            beat_id <= sel;
        end
    end

    // response capture; data and id hold between strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_o0    <= '0;
            bus.rsp_o1    <= '0;
        end else begin
            bus.rsp_valid <= beat_q;
            if (beat_q) begin
                bus.rsp_id <= beat_id;
                bus.rsp_o0 <= bus.shared_o0;
                bus.rsp_o1 <= bus.shared_o1;
            end
        end
    end

endmodule
